// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode and bounce-direction types for the LED pattern generator.
package led_pattern_pkg;
    typedef enum logic [1:0] {MODE_ALT, MODE_CHASE, MODE_BOUNCE, MODE_COUNT} led_mode_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control/LED bundle of the pattern generator; duty exists only with LED_PWM_EN.
interface led_pattern_gen_if
    import led_pattern_pkg::*;
#(
    parameter int N_LED = 8
`ifdef LED_PWM_EN
    , parameter int PWM_W = 8
`endif
);
    logic             en;
    led_mode_t        mode;
`ifdef LED_PWM_EN
    logic [PWM_W-1:0] duty;
`endif
    logic [N_LED-1:0] LED;
    logic             tick;
`ifdef LED_PWM_EN
    modport master (output en, mode, duty, input LED, tick);
    modport slave  (input en, mode, duty, output LED, tick);
`else
    modport master (output en, mode, input LED, tick);
    modport slave  (input en, mode, output LED, tick);
`endif
endinterface

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: divides clk into a one-cycle step strobe every TICK_CYCLES enabled cycles.
module led_tick_prescaler #(
    parameter int TICK_CYCLES = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICK_CYCLES);
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);
    logic [W-1:0] cnt;
    assign tick = en && !clr && cnt == LAST;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: steps an LED pattern (alt/chase/bounce/count) once per prescaler period.
// Define LED_PWM_EN to add a duty input that gates the LEDs with a free-running PWM compare.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_LED       = 8,
    parameter int TICK_CYCLES = 12000000,
    parameter int PWM_W       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    led_pattern_gen_if.slave bus
);
    if (N_LED < 2 || TICK_CYCLES < 2 || PWM_W < 1) begin : g_bad_param
        $error("led_pattern_gen: invalid parameters");
    end
    logic [N_LED-1:0] pattern, nxt;
    dir_t             dir, nxt_dir;
    led_mode_t        mode_q;
    logic             step, mode_chg, tick_q;
    assign mode_chg = bus.mode != mode_q;
    led_tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bus.en),
        .clr  (mode_chg),
        .tick (step)
    );
    always_comb begin
        nxt     = pattern + 1'b1;
        nxt_dir = dir;
        case (mode_q)
            MODE_ALT:   nxt = (pattern == N_LED'(1)) ? N_LED'(2) : N_LED'(1);
            MODE_CHASE: nxt = (pattern == '0) ? N_LED'(1) : {pattern[N_LED-2:0], pattern[N_LED-1]};
            MODE_BOUNCE: begin
                // reverse when the lit bit already sits at the end we are heading towards
                nxt_dir = (pattern == '0) ? DIR_UP :
                          ((dir == DIR_UP ? pattern[N_LED-1] : pattern[0]) ?
                           (dir == DIR_UP ? DIR_DOWN : DIR_UP) : dir);
                nxt     = (pattern == '0) ? N_LED'(1) :
                          (nxt_dir == DIR_UP ? pattern << 1 : pattern >> 1);
            end
            default:    nxt = pattern + 1'b1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_ALT;
            pattern <= '0;
            dir     <= DIR_UP;
            tick_q  <= 1'b0;
        end else if (mode_chg) begin
            mode_q  <= bus.mode;
            pattern <= '0;
            dir     <= DIR_UP;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= step;
            if (step) begin
                pattern <= nxt;
                dir     <= nxt_dir;
            end
        end
    end
    assign bus.tick = tick_q;
`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 1'b1;
    end
    assign bus.LED = pattern & {N_LED{pwm_cnt < bus.duty}};
`else
    assign bus.LED = pattern;
`endif
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen with N_LED=8, TICK_CYCLES=4.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;
    localparam int N  = 8;
    localparam int TC = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [N-1:0] exp_q[$];
    always #5 clk = ~clk;
`ifdef LED_PWM_EN
    led_pattern_gen_if #(.N_LED(N), .PWM_W(8)) bus ();
`else
    led_pattern_gen_if #(.N_LED(N)) bus ();
`endif
    led_pattern_gen #(.N_LED(N), .TICK_CYCLES(TC), .PWM_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic wait_tick(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 20 && !ok) begin
            @(negedge clk);
            cyc++;
            ok = (bus.tick === 1'b1);
        end
    endtask
    task automatic test_reset();
        int cyc; bit ok; logic [N-1:0] e;
        bus.en = 1'b1;
        bus.mode = MODE_ALT;
`ifdef LED_PWM_EN
        bus.duty = 8'd255;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.LED !== '0 || bus.tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: LED=%h tick=%b, want LED=00 tick=0", bus.LED, bus.tick);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back((k % 2 == 0) ? N'(1) : N'(2));
        while (exp_q.size() > 0) begin
            wait_tick(cyc, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || cyc != TC || bus.LED !== e) begin
                n_err++;
                $display("FAIL alt_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=%h", ok, cyc, bus.LED, TC, e);
            end
        end
    endtask
    task automatic test_chase();
        int cyc; bit ok; logic [N-1:0] e;
        bus.mode = MODE_CHASE;
        @(negedge clk);
        n_cmp++;
        if (bus.LED !== '0 || bus.tick !== 1'b0) begin
            n_err++;
            $display("FAIL chase_clear: LED=%h tick=%b, want 00/0", bus.LED, bus.tick);
        end
        for (int k = 0; k < 9; k++) exp_q.push_back(N'(1) << (k % N));
        while (exp_q.size() > 0) begin
            wait_tick(cyc, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || cyc != TC || bus.LED !== e) begin
                n_err++;
                $display("FAIL chase_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=%h", ok, cyc, bus.LED, TC, e);
            end
        end
    endtask
    task automatic test_bounce();
        int cyc; bit ok; int pos; logic [N-1:0] e;
        bus.mode = MODE_BOUNCE;
        @(negedge clk);
        n_cmp++;
        if (bus.LED !== '0) begin
            n_err++;
            $display("FAIL bounce_clear: LED=%h, want 00", bus.LED);
        end
        for (int k = 0; k < 16; k++) begin
            pos = k % (2 * N - 2);
            exp_q.push_back(pos < N ? N'(1) << pos : N'(1) << (2 * N - 2 - pos));
        end
        while (exp_q.size() > 0) begin
            wait_tick(cyc, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || cyc != TC || bus.LED !== e) begin
                n_err++;
                $display("FAIL bounce_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=%h", ok, cyc, bus.LED, TC, e);
            end
        end
    endtask
    task automatic test_count();
        int cyc; bit ok; logic [N-1:0] e;
        bus.mode = MODE_COUNT;
        @(negedge clk);
        for (int k = 0; k < 256; k++) exp_q.push_back(N'(k + 1));
        while (exp_q.size() > 0) begin
            wait_tick(cyc, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || cyc != TC || bus.LED !== e) begin
                n_err++;
                $display("FAIL count_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=%h", ok, cyc, bus.LED, TC, e);
            end
        end
        repeat (2) @(negedge clk);
        bus.mode = MODE_ALT;
        @(negedge clk);
        n_cmp++;
        if (bus.LED !== '0 || bus.tick !== 1'b0) begin
            n_err++;
            $display("FAIL midperiod_switch: LED=%h tick=%b, want 00/0", bus.LED, bus.tick);
        end
        wait_tick(cyc, ok);
        n_cmp++;
        if (!ok || cyc != TC || bus.LED !== N'(1)) begin
            n_err++;
            $display("FAIL switch_first_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=01", ok, cyc, bus.LED, TC);
        end
    endtask
    task automatic test_enable();
        int cyc; bit ok; int bad;
        @(negedge clk);
        bus.en = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.LED !== N'(1) || bus.tick !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL freeze: %0d cycles changed, want 0", bad);
        end
        bus.en = 1'b1;
        wait_tick(cyc, ok);
        n_cmp++;
        if (!ok || cyc != TC - 1 || bus.LED !== N'(2)) begin
            n_err++;
            $display("FAIL resume: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=02", ok, cyc, bus.LED, TC - 1);
        end
        bus.en = 1'b0;
        bus.mode = MODE_CHASE;
        @(negedge clk);
        n_cmp++;
        if (bus.LED !== '0) begin
            n_err++;
            $display("FAIL mode_while_disabled: LED=%h, want 00", bus.LED);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.tick !== 1'b0 || bus.LED !== '0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL disabled_hold: %0d cycles changed, want 0", bad);
        end
        bus.en = 1'b1;
        wait_tick(cyc, ok);
        n_cmp++;
        if (!ok || cyc != TC || bus.LED !== N'(1)) begin
            n_err++;
            $display("FAIL reenable_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=01", ok, cyc, bus.LED, TC);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.LED !== '0 || bus.tick !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: LED=%h tick=%b, want 00/0", bus.LED, bus.tick);
        end
        bus.mode = MODE_ALT;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(cyc, ok);
        n_cmp++;
        if (!ok || cyc != TC || bus.LED !== N'(1)) begin
            n_err++;
            $display("FAIL after_reset_step: seen=%b cycles=%0d LED=%h, want cycles=%0d LED=01", ok, cyc, bus.LED, TC);
        end
    endtask
`ifdef LED_PWM_EN
    task automatic test_pwm();
        int on;
        int duties[3] = '{0, 64, 255};
        bus.en = 1'b0;
        foreach (duties[i]) begin
            bus.duty = 8'(duties[i]);
            @(negedge clk);
            on = 0;
            repeat (256) begin
                @(negedge clk);
                on += int'(bus.LED[0]);
            end
            n_cmp++;
            if (on != duties[i]) begin
                n_err++;
                $display("FAIL pwm_duty: on=%0d of 256, want %0d", on, duties[i]);
            end
        end
        bus.en = 1'b1;
    endtask
`endif
    initial begin
        test_reset();
        test_chase();
        test_bounce();
        test_count();
        test_enable();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
